modulo_controle_ataque: RTL and testbench

//  Upstream attack-entry controller for the 5x7 naval-battle board. Debounces the raw confirm button,

---
 rtl/modulo_controle_ataque_pkg.sv | 38 +++
 rtl/modulo_debounce_contador.sv | 66 ++++++
 rtl/modulo_controle_ataque.sv | 176 +++++++++++++++++
 tb/tb_modulo_controle_ataque.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/modulo_controle_ataque_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : modulo_controle_ataque_pkg                                      |
// | Purpose  : Shared board geometry, shot-result codes, attack FSM state      |
// |            codes and a cell popcount helper for the attack controller.     |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package modulo_controle_ataque_pkg;

  localparam int N_COLS  = 5;
  localparam int N_ROWS  = 7;
  localparam int N_CELLS = 35;

  // Result codes reported for the most recent shot
  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_MISS = 2'b01;
  localparam logic [1:0] RES_HIT  = 2'b10;
  localparam logic [1:0] RES_REJ  = 2'b11;

  // Attack sequencer states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // Number of ship cells on the board; 35 cells always fit in 6 bits
  function automatic logic [5:0] popcount_cells(input logic [N_CELLS-1:0] cells);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      cnt = cnt + 6'(cells[i]);
    end
    return cnt;
  endfunction

endpackage : modulo_controle_ataque_pkg
`default_nettype wire

// File: rtl/modulo_debounce_contador.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : modulo_debounce_contador                                        |
// | Purpose  : Synchronises the raw active-low confirm button, filters bounce  |
// |            with a stability counter and emits a one-cycle press event on   |
// |            each released->pressed change of the filtered level.            |
// | Ports    : clk      in  system clock                                       |
// |            clr      in  asynchronous active-low reset                      |
// |            button_n in  raw push button, pressed = 0                       |
// |            level    out filtered level, 1 = pressed                        |
// |            press    out one-cycle pulse on filtered press                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module modulo_debounce_contador #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic clr,
  input  logic button_n,
  output logic level,
  output logic press
);

  localparam int c_cnt_w = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEB_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_level;
  logic               r_level_d;
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_raw_pressed;

  assign w_raw_pressed = ~r_sync2;

  // Synchroniser flops idle at the released (high) level so reset never
  // looks like a press.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= button_n;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      // Counting only runs while the synchronised level disagrees with the
      // filtered one; any bounce back to agreement reloads the counter.
      if (w_raw_pressed == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_level <= w_raw_pressed;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign press = r_level & ~r_level_d;

endmodule : modulo_debounce_contador
`default_nettype wire

// File: rtl/modulo_controle_ataque.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : modulo_controle_ataque                                          |
// | Purpose  : Attack-entry controller for the 5x7 naval-battle board. Takes a |
// |            debounced confirm press, validates the {col,row} shot, rejects  |
// |            repeats, commits accepted shots to the attacked-cell map,       |
// |            scores them against the ship map and flags game over.           |
// | Ports    : clk            in  system clock                                 |
// |            clr            in  asynchronous active-low reset                |
// |            en_attack      in  attack phase enable (gates new presses)      |
// |            button_confirm in  raw confirm button, pressed = 0              |
// |            at_in[5:0]     in  shot coordinate {col[2:0], row[2:0]}         |
// |            ship_map[34:0] in  ship cells, bit 34-(row*5+col)               |
// |            attacked[34:0] out cells already shot, same mapping             |
// |            result[1:0]    out last shot: none/miss/hit/rejected            |
// |            result_valid   out one-cycle pulse when result updates          |
// |            hits[5:0]      out accepted hits                                |
// |            shots[5:0]     out accepted shots, saturating at 35             |
// |            game_over      out sticky, all ship cells hit                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module modulo_controle_ataque #(
  parameter int DEB_CYCLES = 50000,
  parameter int N_COLS     = modulo_controle_ataque_pkg::N_COLS,
  parameter int N_ROWS     = modulo_controle_ataque_pkg::N_ROWS
) (
  input  logic                                        clk,
  input  logic                                        clr,
  input  logic                                        en_attack,
  input  logic                                        button_confirm,
  input  logic [5:0]                                  at_in,
  input  logic [modulo_controle_ataque_pkg::N_CELLS-1:0] ship_map,
  output logic [modulo_controle_ataque_pkg::N_CELLS-1:0] attacked,
  output logic [1:0]                                  result,
  output logic                                        result_valid,
  output logic [5:0]                                  hits,
  output logic [5:0]                                  shots,
  output logic                                        game_over
);

  import modulo_controle_ataque_pkg::*;

  localparam logic [5:0] c_pos_max   = 6'(N_CELLS - 1);
  localparam logic [5:0] c_shots_max = 6'(N_CELLS);

  logic               w_level;
  logic               w_press;

  logic [1:0]         r_state;
  logic [1:0]         w_next;

  logic [2:0]         w_col;
  logic [2:0]         w_row;
  logic               w_in_range;
  logic [5:0]         w_idx;
  logic [5:0]         w_pos;
  logic [N_CELLS-1:0] w_mask;
  logic               w_repeat;
  logic               w_reject;

  logic [N_CELLS-1:0] r_mask;
  logic               r_reject;
  logic [N_CELLS-1:0] r_attacked;
  logic [1:0]         r_result;
  logic [5:0]         r_hits;
  logic [5:0]         r_shots;
  logic               r_game_over;

  logic               w_commit;
  logic               w_accept;
  logic               w_hit;
  logic [1:0]         w_commit_res;
  logic [5:0]         w_ship_cnt;
  logic               w_go_now;

  modulo_debounce_contador #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .clr     (clr),
    .button_n(button_confirm),
    .level   (w_level),
    .press   (w_press)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_press && en_attack) w_next = ST_CHECK;
      ST_CHECK:  w_next = ST_COMMIT;
      ST_COMMIT: w_next = ST_HOLD;
      ST_HOLD:   if (!w_level) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // The commit result is shown combinationally during COMMIT so that
  // result_valid lands two cycles after the press event; the registered copy
  // holds it afterwards.
  always_comb begin
    w_commit     = (r_state == ST_COMMIT);
    w_accept     = w_commit && !r_reject;
    result_valid = w_commit;
    result       = w_commit ? w_commit_res : r_result;
  end

  // ---------------- Coordinate check (used in CHECK) ----------------
  assign w_col      = at_in[5:3];
  assign w_row      = at_in[2:0];
  assign w_in_range = (int'(w_col) < N_COLS) && (int'(w_row) < N_ROWS);
  assign w_idx      = 6'(w_row) * 6'(N_COLS) + 6'(w_col);
  // Cell 0 lives in the MSB; out-of-range coordinates never produce a mask
  // bit, so the wrapped subtraction is harmless.
  assign w_pos      = c_pos_max - w_idx;
  assign w_mask     = w_in_range ? (N_CELLS'(1) << w_pos) : '0;
  assign w_repeat   = |(r_attacked & w_mask);
  assign w_reject   = !w_in_range || w_repeat || game_over;

  // Scoring uses the ship map present during COMMIT
  assign w_hit        = |(ship_map & r_mask);
  assign w_commit_res = r_reject ? RES_REJ : (w_hit ? RES_HIT : RES_MISS);

  assign w_ship_cnt = popcount_cells(ship_map);
  assign w_go_now   = (r_hits == w_ship_cnt) && (w_ship_cnt != 6'd0);

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_mask      <= '0;
      r_reject    <= 1'b0;
      r_attacked  <= '0;
      r_result    <= RES_NONE;
      r_hits      <= '0;
      r_shots     <= '0;
      r_game_over <= 1'b0;
    end else begin
      if (r_state == ST_CHECK) begin
        r_mask   <= w_mask;
        r_reject <= w_reject;
      end
      if (w_commit) begin
        r_result <= w_commit_res;
      end
      if (w_accept) begin
        r_attacked <= r_attacked | r_mask;
        if (r_shots != c_shots_max) begin
          r_shots <= r_shots + 6'd1;
        end
        if (w_hit) begin
          r_hits <= r_hits + 6'd1;
        end
      end
      if (w_go_now) begin
        r_game_over <= 1'b1;
      end
    end
  end

  assign attacked  = r_attacked;
  assign hits      = r_hits;
  assign shots     = r_shots;
  assign game_over = r_game_over | w_go_now;

endmodule : modulo_controle_ataque
`default_nettype wire

// File: tb/tb_modulo_controle_ataque.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_modulo_controle_ataque                                       |
// | Purpose  : Directed self-checking bench for modulo_controle_ataque with    |
// |            a 4-cycle debounce window.                                      |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_modulo_controle_ataque;

  logic        clk;
  logic        clr;
  logic        en_attack;
  logic        button_confirm;
  logic [5:0]  at_in;
  logic [34:0] ship_map;
  logic [34:0] attacked;
  logic [1:0]  result;
  logic        result_valid;
  logic [5:0]  hits;
  logic [5:0]  shots;
  logic        game_over;

  int n_cmp;
  int n_err;

  modulo_controle_ataque #(
    .DEB_CYCLES(4),
    .N_COLS    (5),
    .N_ROWS    (7)
  ) dut (
    .clk           (clk),
    .clr           (clr),
    .en_attack     (en_attack),
    .button_confirm(button_confirm),
    .at_in         (at_in),
    .ship_map      (ship_map),
    .attacked      (attacked),
    .result        (result),
    .result_valid  (result_valid),
    .hits          (hits),
    .shots         (shots),
    .game_over     (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Press on a negedge, hold 30 cycles, release and let the FSM return to
  // IDLE. Returns the number of result_valid pulses seen, the first result
  // and its latency in posedges counted from the press.
  task automatic do_shot(input logic [5:0] coord, output int n_rv,
                         output logic [1:0] res, output int lat);
    @(negedge clk);
    at_in          = coord;
    button_confirm = 1'b0;
    n_rv = 0;
    lat  = -1;
    res  = 2'b00;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (result_valid) begin
        n_rv++;
        if (lat < 0) begin
          lat = i;
          res = result;
        end
      end
    end
    button_confirm = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (result_valid) n_rv++;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    button_confirm = 1'b1;
    clr = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (result !== 2'b00) begin n_err++; $display("FAIL reset_result got=%b exp=00", result); end
    n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL reset_rv got=%b exp=0", result_valid); end
    n_cmp++; if (attacked !== 35'd0) begin n_err++; $display("FAIL reset_attacked got=%h exp=0", attacked); end
    n_cmp++; if (hits !== 6'd0 || shots !== 6'd0) begin n_err++; $display("FAIL reset_counts got hits=%0d shots=%0d exp 0/0", hits, shots); end
    n_cmp++; if (game_over !== 1'b0) begin n_err++; $display("FAIL reset_game_over got=%b exp=0", game_over); end
  endtask

  task automatic test_hit_latency();
    int n_rv; int lat; logic [1:0] res;
    ship_map = (35'd1 << 17) | (35'd1 << 10);
    do_shot({3'd2, 3'd3}, n_rv, res, lat);
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL hit_latency got=%0d exp=8", lat); end
    n_cmp++; if (n_rv !== 1) begin n_err++; $display("FAIL hit_pulses got=%0d exp=1", n_rv); end
    n_cmp++; if (res !== 2'b10) begin n_err++; $display("FAIL hit_result got=%b exp=10", res); end
    n_cmp++; if (attacked !== (35'd1 << 17)) begin n_err++; $display("FAIL hit_attacked got=%h exp=%h", attacked, 35'd1 << 17); end
    n_cmp++; if (hits !== 6'd1 || shots !== 6'd1) begin n_err++; $display("FAIL hit_counts got hits=%0d shots=%0d exp 1/1", hits, shots); end
    n_cmp++; if (game_over !== 1'b0) begin n_err++; $display("FAIL hit_game_over got=%b exp=0", game_over); end
  endtask

  task automatic test_repeat();
    int n_rv; int lat; logic [1:0] res;
    do_shot({3'd2, 3'd3}, n_rv, res, lat);
    n_cmp++; if (res !== 2'b11) begin n_err++; $display("FAIL repeat_result got=%b exp=11", res); end
    n_cmp++; if (attacked !== (35'd1 << 17) || hits !== 6'd1 || shots !== 6'd1) begin n_err++; $display("FAIL repeat_state got att=%h hits=%0d shots=%0d exp %h/1/1", attacked, hits, shots, 35'd1 << 17); end
  endtask

  task automatic test_invalid_then_miss();
    int n_rv; int lat; logic [1:0] res;
    do_shot({3'd5, 3'd0}, n_rv, res, lat);
    n_cmp++; if (res !== 2'b11 || n_rv !== 1) begin n_err++; $display("FAIL col_range got res=%b pulses=%0d exp 11/1", res, n_rv); end
    do_shot({3'd0, 3'd7}, n_rv, res, lat);
    n_cmp++; if (res !== 2'b11) begin n_err++; $display("FAIL row_range got=%b exp=11", res); end
    n_cmp++; if (attacked !== (35'd1 << 17) || shots !== 6'd1) begin n_err++; $display("FAIL invalid_state got att=%h shots=%0d", attacked, shots); end
    do_shot({3'd4, 3'd6}, n_rv, res, lat);
    n_cmp++; if (res !== 2'b01) begin n_err++; $display("FAIL miss_result got=%b exp=01", res); end
    n_cmp++; if (attacked !== ((35'd1 << 17) | 35'd1)) begin n_err++; $display("FAIL miss_attacked got=%h exp=%h", attacked, (35'd1 << 17) | 35'd1); end
    n_cmp++; if (hits !== 6'd1 || shots !== 6'd2) begin n_err++; $display("FAIL miss_counts got hits=%0d shots=%0d exp 1/2", hits, shots); end
  endtask

  task automatic test_bounce();
    int n_rv;
    n_rv = 0;
    @(negedge clk);
    at_in = {3'd0, 3'd0};
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) button_confirm = ~button_confirm;
      @(posedge clk); #1;
      if (result_valid) n_rv++;
      @(negedge clk);
    end
    button_confirm = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (result_valid) n_rv++;
    end
    button_confirm = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (result_valid) n_rv++;
    end
    n_cmp++; if (n_rv !== 1) begin n_err++; $display("FAIL bounce_pulses got=%0d exp=1", n_rv); end
    n_cmp++; if (attacked[34] !== 1'b1 || shots !== 6'd3) begin n_err++; $display("FAIL bounce_state got att34=%b shots=%0d exp 1/3", attacked[34], shots); end
  endtask

  task automatic test_en_gate();
    int n_rv; int lat; logic [1:0] res;
    en_attack = 1'b0;
    do_shot({3'd1, 3'd1}, n_rv, res, lat);
    en_attack = 1'b1;
    n_cmp++; if (n_rv !== 0) begin n_err++; $display("FAIL en_gate_pulses got=%0d exp=0", n_rv); end
    n_cmp++; if (shots !== 6'd3 || attacked[28] !== 1'b0) begin n_err++; $display("FAIL en_gate_state got shots=%0d att28=%b exp 3/0", shots, attacked[28]); end
  endtask

  task automatic test_game_over();
    int n_rv; int lat; logic [1:0] res;
    ship_map = (35'd1 << 34) | (35'd1 << 28) | 35'd1;
    apply_reset();
    do_shot({3'd0, 3'd0}, n_rv, res, lat);
    do_shot({3'd1, 3'd1}, n_rv, res, lat);
    n_cmp++; if (hits !== 6'd2 || game_over !== 1'b0) begin n_err++; $display("FAIL go_two_hits got hits=%0d go=%b exp 2/0", hits, game_over); end
    do_shot({3'd4, 3'd6}, n_rv, res, lat);
    n_cmp++; if (res !== 2'b10 || hits !== 6'd3 || game_over !== 1'b1) begin n_err++; $display("FAIL go_third got res=%b hits=%0d go=%b exp 10/3/1", res, hits, game_over); end
    do_shot({3'd2, 3'd2}, n_rv, res, lat);
    n_cmp++; if (res !== 2'b11 || n_rv !== 1) begin n_err++; $display("FAIL go_after_result got res=%b pulses=%0d exp 11/1", res, n_rv); end
    n_cmp++; if (shots !== 6'd3 || attacked !== ((35'd1 << 34) | (35'd1 << 28) | 35'd1) || game_over !== 1'b1) begin n_err++; $display("FAIL go_after_state got shots=%0d att=%h go=%b", shots, attacked, game_over); end
  endtask

  task automatic test_reset_in_commit();
    int n_rv; int lat; logic [1:0] res; int waited; logic seen;
    ship_map = (35'd1 << 17) | (35'd1 << 10);
    apply_reset();
    do_shot({3'd2, 3'd3}, n_rv, res, lat);
    n_cmp++; if (hits !== 6'd1) begin n_err++; $display("FAIL rc_setup got hits=%0d exp=1", hits); end
    @(negedge clk);
    at_in = {3'd4, 3'd4};
    button_confirm = 1'b0;
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 40) begin
      @(posedge clk); #1;
      waited++;
      if (result_valid) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL rc_no_commit got=timeout exp=result_valid"); end
    clr = 1'b0;
    #1;
    n_cmp++; if (result_valid !== 1'b0 || result !== 2'b00) begin n_err++; $display("FAIL rc_async_result got rv=%b res=%b exp 0/00", result_valid, result); end
    n_cmp++; if (attacked !== 35'd0 || hits !== 6'd0 || shots !== 6'd0 || game_over !== 1'b0) begin n_err++; $display("FAIL rc_async_state got att=%h hits=%0d shots=%0d go=%b exp all 0", attacked, hits, shots, game_over); end
    button_confirm = 1'b1;
    @(negedge clk);
    clr = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++; if (attacked !== 35'd0 || hits !== 6'd0 || shots !== 6'd0) begin n_err++; $display("FAIL rc_no_partial got att=%h hits=%0d shots=%0d exp all 0", attacked, hits, shots); end
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    clr            = 1'b0;
    en_attack      = 1'b1;
    button_confirm = 1'b1;
    at_in          = 6'd0;
    ship_map       = 35'd0;
    test_reset();
    test_hit_latency();
    test_repeat();
    test_invalid_then_miss();
    test_bounce();
    test_en_gate();
    test_game_over();
    test_reset_in_commit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_modulo_controle_ataque
`default_nettype wire
